// File: rtl/md_unit.sv
// Multiply/divide unit for the EX stage: owns HI/LO, runs mult/div as fixed-latency
// operations and signals Busy so hazard control can stall later md instructions.
module md_unit #(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] thi_q, thi_d, tlo_q, tlo_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, b_mag_nz, b_nz;
    logic [31:0] qs_mag, rs_mag, q_s, r_s, q_u, r_u;

    always_comb begin
        prod_s   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u   = {32'd0, A} * {32'd0, B};
        // Magnitudes wrap for 0x80000000, which still divides correctly as unsigned.
        a_mag    = A[31] ? (~A + 32'd1) : A;
        b_mag    = B[31] ? (~B + 32'd1) : B;
        b_mag_nz = (b_mag == 32'd0) ? 32'd1 : b_mag;
        b_nz     = (B == 32'd0) ? 32'd1 : B;
        qs_mag   = a_mag / b_mag_nz;
        rs_mag   = a_mag % b_mag_nz;
        q_s      = (A[31] ^ B[31]) ? (~qs_mag + 32'd1) : qs_mag;
        r_s      = A[31] ? (~rs_mag + 32'd1) : rs_mag;
        q_u      = A / b_nz;
        r_u      = A % b_nz;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        thi_d   = thi_q;
        tlo_d   = tlo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    case (MDOp)
                        3'd1: begin
                            {thi_d, tlo_d} = prod_s;
                            cnt_d          = 4'(MUL_LAT);
                            state_d        = StRun;
                        end
                        3'd2: begin
                            {thi_d, tlo_d} = prod_u;
                            cnt_d          = 4'(MUL_LAT);
                            state_d        = StRun;
                        end
                        3'd3, 3'd4: begin
                            // Divide by zero commits the current HI/LO back unchanged.
                            if (B == 32'd0) begin
                                thi_d = hi_q;
                                tlo_d = lo_q;
                            end else if (MDOp == 3'd3) begin
                                thi_d = r_s;
                                tlo_d = q_s;
                            end else begin
                                thi_d = r_u;
                                tlo_d = q_u;
                            end
                            cnt_d   = 4'(DIV_LAT);
                            state_d = StRun;
                        end
                        3'd5:    hi_d = A;
                        3'd6:    lo_d = A;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    hi_d    = thi_q;
                    lo_d    = tlo_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            thi_q   <= 32'd0;
            tlo_q   <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            thi_q   <= thi_d;
            tlo_q   <= tlo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign Busy = (state_q == StRun);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
